fadd_share_sched: RTL and testbench

Round-robin scheduler that shares one pipelined single-precision `float_add` instance among `N_REQ` requesters. Each requester presents an operand pair under a valid/ready handshake. The scheduler issues at most one pair per enabled cycle and tags it with the requester index through a shadow pipeline matched to the adder latency. It then returns the sum with that tag. It sits between the geometry/transform stages and the adder, and replaces per-stage adder instances.

---
 rtl/flight_math_pkg.sv | 11 +
 rtl/rr_arbiter.sv | 36 +++
 rtl/fadd_share_sched.sv | 102 ++++++++++
 tb/tb_fadd_share_sched.sv | 326 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/flight_math_pkg.sv
// Shared float constants for the flight-math datapath blocks.
package flight_math_pkg;

  localparam int FLOAT_W          = 32;
  localparam int FADD_LAT_DEFAULT = 7;

  localparam logic [FLOAT_W-1:0] F_ONE   = 32'h3F80_0000;
  localparam logic [FLOAT_W-1:0] F_TWO   = 32'h4000_0000;
  localparam logic [FLOAT_W-1:0] F_THREE = 32'h4040_0000;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: grants the first request at or after ptr.
module rr_arbiter #(
  parameter int N    = 4,
  parameter int ID_W = 2
) (
  input  logic [N-1:0]    req,
  input  logic [ID_W-1:0] ptr,
  input  logic            en,
  output logic [N-1:0]    gnt,
  output logic [ID_W-1:0] gnt_id,
  output logic            any
);

  // Circular search starting at ptr; the first hit wins.
  always_comb begin
    int tgt;
    gnt    = '0;
    gnt_id = '0;
    any    = 1'b0;
    tgt    = 0;
    if (en) begin
      for (int k = 0; k < N; k++) begin
        tgt = int'(ptr) + k;
        if (tgt >= N) tgt = tgt - N;
        for (int j = 0; j < N; j++) begin
          if (!any && (j == tgt) && req[j]) begin
            gnt[j] = 1'b1;
            gnt_id = ID_W'(j);
            any    = 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: rtl/fadd_share_sched.sv
// Shares one pipelined float adder among N_REQ requesters. Accepted operand
// pairs are issued one per enabled cycle; a shadow tag pipeline matched to the
// adder latency returns each sum with the index of the requester that owns it.
module fadd_share_sched
  import flight_math_pkg::*;
#(
  parameter int N_REQ   = 4,
  parameter int ADD_LAT = FADD_LAT_DEFAULT,
  parameter int ID_W    = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic                     clock,
  input  logic                     aclr,
  input  logic                     clk_en,
  input  logic [N_REQ-1:0]         req_valid,
  input  logic [FLOAT_W*N_REQ-1:0] req_a,
  input  logic [FLOAT_W*N_REQ-1:0] req_b,
  output logic [N_REQ-1:0]         req_ready,
  output logic [FLOAT_W-1:0]       add_dataa,
  output logic [FLOAT_W-1:0]       add_datab,
  output logic                     add_clk_en,
  input  logic [FLOAT_W-1:0]       add_result,
  output logic                     rsp_valid,
  output logic [ID_W-1:0]          rsp_id,
  output logic [FLOAT_W-1:0]       rsp_data,
  output logic [4:0]               inflight
);

  logic [ID_W-1:0]    ptr_q, ptr_d;
  logic [ID_W-1:0]    gnt_id;
  logic               accept;
  logic               rsp_fire;
  logic [FLOAT_W-1:0] a_sel, b_sel;
  logic [FLOAT_W-1:0] dataa_q, datab_q;
  logic [ADD_LAT:0]   tvld_q;
  logic [ID_W-1:0]    tid_q [0:ADD_LAT];
  logic [4:0]         inflight_q, inflight_d;

  // The arbiter only grants asserted requests, so any grant is an acceptance.
  rr_arbiter #(.N(N_REQ), .ID_W(ID_W)) u_arb (
    .req    (req_valid),
    .ptr    (ptr_q),
    .en     (clk_en),
    .gnt    (req_ready),
    .gnt_id (gnt_id),
    .any    (accept)
  );

  assign rsp_fire = tvld_q[ADD_LAT] & clk_en;

  // Operand select, pointer advance and in-flight count next-state.
  always_comb begin
    a_sel = '0;
    b_sel = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (req_ready[i]) begin
        a_sel = req_a[i*FLOAT_W +: FLOAT_W];
        b_sel = req_b[i*FLOAT_W +: FLOAT_W];
      end
    end
    ptr_d = ptr_q;
    if (accept) ptr_d = (int'(gnt_id) == N_REQ - 1) ? '0 : gnt_id + ID_W'(1);
    inflight_d = inflight_q + {4'd0, accept} - {4'd0, rsp_fire};
  end

  // Control state: pointer, in-flight count and issue register.
  always_ff @(posedge clock or posedge aclr) begin
    if (aclr) begin
      ptr_q      <= '0;
      inflight_q <= '0;
      dataa_q    <= '0;
      datab_q    <= '0;
    end else begin
      ptr_q      <= ptr_d;
      inflight_q <= inflight_d;
      if (accept) begin
        dataa_q <= a_sel;
        datab_q <= b_sel;
      end
    end
  end

  // Tag pipeline: stage 0 sees the issue edge, the last stage lines up with add_result.
  always_ff @(posedge clock or posedge aclr) begin
    if (aclr) begin
      tvld_q <= '0;
      for (int i = 0; i <= ADD_LAT; i++) tid_q[i] <= '0;
    end else if (clk_en) begin
      tvld_q   <= {tvld_q[ADD_LAT-1:0], accept};
      tid_q[0] <= gnt_id;
      for (int i = 1; i <= ADD_LAT; i++) tid_q[i] <= tid_q[i-1];
    end
  end

  assign add_dataa  = dataa_q;
  assign add_datab  = datab_q;
  assign add_clk_en = clk_en;
  assign rsp_valid  = tvld_q[ADD_LAT];
  assign rsp_id     = tid_q[ADD_LAT];
  assign rsp_data   = add_result;
  assign inflight   = inflight_q;

endmodule

// File: tb/tb_fadd_share_sched.sv
// Bench for fadd_share_sched with a behavioural pipelined adder model and a
// response scoreboard.
`timescale 1ns/1ps
module tb_fadd_share_sched;
  import flight_math_pkg::*;

  localparam int N_REQ   = 4;
  localparam int ADD_LAT = 7;
  localparam int ID_W    = 2;

  logic                     clock = 1'b0;
  logic                     aclr = 1'b1;
  logic                     clk_en = 1'b1;
  logic [N_REQ-1:0]         req_valid = '0;
  logic [FLOAT_W*N_REQ-1:0] req_a = '0;
  logic [FLOAT_W*N_REQ-1:0] req_b = '0;
  logic [N_REQ-1:0]         req_ready;
  logic [FLOAT_W-1:0]       add_dataa, add_datab, add_result, rsp_data;
  logic                     add_clk_en, rsp_valid;
  logic [ID_W-1:0]          rsp_id;
  logic [4:0]               inflight;

  int tests = 0;
  int fails = 0;

  typedef struct packed {
    logic [ID_W-1:0]    id;
    logic [FLOAT_W-1:0] sum;
  } exp_t;
  exp_t sb[$];
  exp_t e_pop, e_push;

  fadd_share_sched #(.N_REQ(N_REQ), .ADD_LAT(ADD_LAT)) dut (
    .clock(clock), .aclr(aclr), .clk_en(clk_en),
    .req_valid(req_valid), .req_a(req_a), .req_b(req_b), .req_ready(req_ready),
    .add_dataa(add_dataa), .add_datab(add_datab), .add_clk_en(add_clk_en),
    .add_result(add_result), .rsp_valid(rsp_valid), .rsp_id(rsp_id),
    .rsp_data(rsp_data), .inflight(inflight)
  );

  always #5 clock = ~clock;

  // Positive normal operands only; truncating single-precision add.
  function automatic logic [31:0] fadd(input logic [31:0] a_in, input logic [31:0] b_in);
    logic [31:0] a, b;
    logic [7:0]  e;
    logic [24:0] ma, mb, m;
    a = a_in; b = b_in;
    if (b[30:23] > a[30:23]) begin a = b_in; b = a_in; end
    e  = a[30:23];
    ma = {2'b01, a[22:0]};
    mb = {2'b01, b[22:0]} >> (a[30:23] - b[30:23]);
    m  = ma + mb;
    if (m[24]) begin m = m >> 1; e = e + 8'd1; end
    return {1'b0, e, m[22:0]};
  endfunction

  function automatic logic [31:0] rand_float();
    return {1'b0, 8'(120 + $urandom_range(0, 15)), 23'($urandom)};
  endfunction

  // External adder model: ADD_LAT enabled stages.
  logic [31:0] apipe [0:ADD_LAT-1];
  always @(posedge clock or posedge aclr) begin
    if (aclr) begin
      for (int i = 0; i < ADD_LAT; i++) apipe[i] <= '0;
    end else if (add_clk_en) begin
      apipe[0] <= fadd(add_dataa, add_datab);
      for (int i = 1; i < ADD_LAT; i++) apipe[i] <= apipe[i-1];
    end
  end
  assign add_result = apipe[ADD_LAT-1];

  // Scoreboard: pop on each enabled response, push on each handshake.
  always @(negedge clock) begin
    if (aclr) begin
      sb.delete();
    end else begin
      if (rsp_valid && clk_en) begin
        tests++;
        if (sb.size() == 0) begin
          fails++;
          $display("FAIL sb_unexpected: got id=%0d data=%h, required no response", rsp_id, rsp_data);
        end else begin
          e_pop = sb.pop_front();
          if (rsp_id !== e_pop.id || rsp_data !== e_pop.sum) begin
            fails++;
            $display("FAIL sb_resp: got id=%0d data=%h, required id=%0d data=%h",
                     rsp_id, rsp_data, e_pop.id, e_pop.sum);
          end
        end
      end
      for (int i = 0; i < N_REQ; i++) begin
        if (req_valid[i] && req_ready[i]) begin
          e_push.id  = ID_W'(i);
          e_push.sum = fadd(req_a[i*32 +: 32], req_b[i*32 +: 32]);
          sb.push_back(e_push);
        end
      end
    end
  end

  task automatic drive_cycle();
    @(posedge clock); #1;
  endtask

  task automatic randomize_ops();
    for (int i = 0; i < N_REQ; i++) begin
      req_a[i*32 +: 32] = rand_float();
      req_b[i*32 +: 32] = rand_float();
    end
  endtask

  task automatic do_reset();
    drive_cycle();
    aclr = 1'b1; req_valid = '0; clk_en = 1'b1;
    drive_cycle();
    aclr = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    req_valid = '0;
    while ((inflight != 0 || sb.size() != 0) && n < 40) begin
      @(negedge clock);
      n++;
    end
    tests++;
    if (inflight !== 5'd0 || sb.size() != 0) begin
      fails++;
      $display("FAIL %s_drain: got inflight=%0d pending=%0d, required 0 and 0", name, inflight, sb.size());
    end
  endtask

  task automatic test_reset();
    aclr = 1'b1; clk_en = 1'b1; req_valid = '0;
    repeat (2) @(negedge clock);
    tests++; if (rsp_valid !== 1'b0) begin fails++; $display("FAIL rst_rsp_valid: got %b, required 0", rsp_valid); end
    tests++; if (rsp_id !== '0) begin fails++; $display("FAIL rst_rsp_id: got %0d, required 0", rsp_id); end
    tests++; if (inflight !== 5'd0) begin fails++; $display("FAIL rst_inflight: got %0d, required 0", inflight); end
    tests++; if (add_dataa !== 32'd0) begin fails++; $display("FAIL rst_dataa: got %h, required 0", add_dataa); end
    tests++; if (add_datab !== 32'd0) begin fails++; $display("FAIL rst_datab: got %h, required 0", add_datab); end
    drive_cycle();
    aclr = 1'b0;
    @(negedge clock);
    tests++; if (req_ready !== 4'b0000) begin fails++; $display("FAIL rst_ready_idle: got %b, required 0000", req_ready); end
    tests++; if (add_clk_en !== 1'b1) begin fails++; $display("FAIL add_clk_en: got %b, required 1", add_clk_en); end
  endtask

  task automatic test_single();
    int lat;
    lat = 0;
    drive_cycle();
    req_valid = 4'b0100;
    req_a[64 +: 32] = F_ONE;
    req_b[64 +: 32] = F_TWO;
    @(negedge clock);
    tests++; if (req_ready !== 4'b0100) begin fails++; $display("FAIL single_grant: got %b, required 0100", req_ready); end
    for (int k = 1; k <= 12; k++) begin
      drive_cycle();
      req_valid = '0;
      @(negedge clock);
      if (k == 1) begin
        tests++; if (inflight !== 5'd1) begin fails++; $display("FAIL single_inflight1: got %0d, required 1", inflight); end
      end
      if (rsp_valid && lat == 0) begin
        lat = k;
        tests++; if (rsp_id !== 2'd2) begin fails++; $display("FAIL single_id: got %0d, required 2", rsp_id); end
        tests++; if (rsp_data !== F_THREE) begin fails++; $display("FAIL single_data: got %h, required %h", rsp_data, F_THREE); end
      end
    end
    tests++; if (lat !== 8) begin fails++; $display("FAIL single_latency: got %0d, required 8", lat); end
    tests++; if (inflight !== 5'd0) begin fails++; $display("FAIL single_inflight_end: got %0d, required 0", inflight); end
  endtask

  task automatic test_fairness();
    int ok_cnt, bad;
    ok_cnt = 0; bad = 0;
    do_reset();
    for (int j = 0; j < 24; j++) begin
      if (j > 0) drive_cycle();
      req_valid = (j < 8) ? 4'b1111 : 4'b0000;
      randomize_ops();
      @(negedge clock);
      if (j < 8) begin
        tests++;
        if (req_ready !== 4'(1 << (j % 4))) begin
          fails++;
          $display("FAIL fair_grant_%0d: got %b, required %b", j, req_ready, 4'(1 << (j % 4)));
        end
      end
      if (rsp_valid) begin
        if (j >= 8 && j < 16 && rsp_id == ID_W'((j - 8) % 4)) ok_cnt++;
        else bad++;
      end
    end
    tests++;
    if (ok_cnt != 8 || bad != 0) begin
      fails++;
      $display("FAIL fair_rsp_order: got %0d in-order, %0d misplaced, required 8 and 0", ok_cnt, bad);
    end
    wait_idle("fair");
  endtask

  task automatic test_back_to_back();
    int acc, peak, cnt, first, last;
    acc = 0; peak = 0; cnt = 0; first = -1; last = -1;
    for (int j = 0; j < 40; j++) begin
      drive_cycle();
      req_valid = (j < 20) ? 4'b0001 : 4'b0000;
      randomize_ops();
      @(negedge clock);
      if (req_valid[0] && req_ready[0]) acc++;
      if (int'(inflight) > peak) peak = int'(inflight);
      if (rsp_valid) begin
        if (first < 0) first = j;
        last = j;
        cnt++;
      end
    end
    tests++; if (acc != 20) begin fails++; $display("FAIL b2b_accepts: got %0d, required 20", acc); end
    tests++; if (peak != 8) begin fails++; $display("FAIL b2b_peak_inflight: got %0d, required 8", peak); end
    tests++; if (cnt != 20) begin fails++; $display("FAIL b2b_responses: got %0d, required 20", cnt); end
    tests++;
    if (first != 8 || last - first + 1 != 20) begin
      fails++;
      $display("FAIL b2b_rsp_window: got first=%0d last=%0d, required 8 and 27", first, last);
    end
    wait_idle("b2b");
  endtask

  task automatic test_stall();
    int cnt, first;
    cnt = 0; first = -1;
    for (int j = 0; j < 18; j++) begin
      drive_cycle();
      randomize_ops();
      if (j >= 4 && j <= 6) begin
        clk_en = 1'b0; req_valid = 4'b1111;
      end else begin
        clk_en = 1'b1; req_valid = (j == 0) ? 4'b0010 : 4'b0000;
      end
      @(negedge clock);
      if (j == 0) begin
        tests++; if (req_ready !== 4'b0010) begin fails++; $display("FAIL stall_accept: got %b, required 0010", req_ready); end
      end
      if (j >= 4 && j <= 6) begin
        tests++; if (req_ready !== 4'b0000) begin fails++; $display("FAIL stall_ready_%0d: got %b, required 0000", j, req_ready); end
      end
      if (rsp_valid && clk_en) begin
        if (first < 0) first = j;
        cnt++;
      end
    end
    clk_en = 1'b1;
    tests++; if (first != 11) begin fails++; $display("FAIL stall_latency: got %0d, required 11", first); end
    tests++; if (cnt != 1) begin fails++; $display("FAIL stall_count: got %0d, required 1", cnt); end
    wait_idle("stall");
  endtask

  task automatic test_reset_midflight();
    int cnt;
    cnt = 0;
    for (int j = 0; j < 5; j++) begin
      drive_cycle();
      randomize_ops();
      req_valid = (j < 3) ? 4'b0010 : 4'b0000;
      if (j == 4) begin aclr = 1'b1; req_valid = 4'b1111; end
      @(negedge clock);
    end
    tests++; if (inflight !== 5'd0) begin fails++; $display("FAIL rmid_inflight: got %0d, required 0", inflight); end
    tests++; if (rsp_valid !== 1'b0) begin fails++; $display("FAIL rmid_rsp_valid: got %b, required 0", rsp_valid); end
    tests++; if (req_ready !== 4'b0001) begin fails++; $display("FAIL rmid_ptr: got ready=%b, required 0001", req_ready); end
    drive_cycle();
    aclr = 1'b0; req_valid = '0;
    for (int j = 0; j < 16; j++) begin
      @(negedge clock);
      if (rsp_valid) cnt++;
    end
    tests++; if (cnt != 0) begin fails++; $display("FAIL rmid_ghost_rsp: got %0d responses, required 0", cnt); end
    wait_idle("rmid");
  endtask

  task automatic test_sparse();
    drive_cycle();
    randomize_ops();
    req_valid = 4'b0010;
    drive_cycle();
    req_valid = 4'b0000;
    drive_cycle();
    req_valid = 4'b1010;
    @(negedge clock);
    tests++; if (req_ready !== 4'b1000) begin fails++; $display("FAIL sparse_first: got %b, required 1000", req_ready); end
    drive_cycle();
    @(negedge clock);
    tests++; if (req_ready !== 4'b0010) begin fails++; $display("FAIL sparse_second: got %b, required 0010", req_ready); end
    drive_cycle();
    req_valid = 4'b0000;
    wait_idle("sparse");
  endtask

  initial begin
    test_reset();
    test_single();
    test_fairness();
    test_back_to_back();
    test_stall();
    test_reset_midflight();
    test_sparse();
    tests++;
    if (sb.size() != 0) begin
      fails++;
      $display("FAIL sb_leftover: got %0d pending, required 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
